// File: rtl/img_proc_pkg.sv
// Shared image-processing definitions: default frame geometry
// and the blob_centroid controller state encoding.
package img_proc_pkg;

  localparam int DEF_FRAME_W = 640;
  localparam int DEF_FRAME_H = 480;
  localparam int DEF_PIX_W   = 12;

  typedef logic [1:0] blob_state_t;

  localparam blob_state_t ST_IDLE  = 2'd0;
  localparam blob_state_t ST_DIV_X = 2'd1;
  localparam blob_state_t ST_DIV_Y = 2'd2;
  localparam blob_state_t ST_HOLD  = 2'd3;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The quotient is built in place of the dividend register.
module seq_divider #(
  parameter int DVD_W = 17,
  parameter int DVS_W = 6,
  parameter int QUO_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [QUO_W-1:0] quotient_o
);

  localparam int CW = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] dvd_q, dvd_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DVS_W:0]   shifted;
  logic [DVS_W+1:0] diff;
  logic             qbit;

  always_comb begin
    shifted = {rem_q, dvd_q[DVD_W-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs_q};
    qbit    = ~diff[DVS_W+1];
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (busy_q) begin
      rem_d = qbit ? diff[DVS_W-1:0] : shifted[DVS_W-1:0];
      dvd_d = {dvd_q[DVD_W-2:0], qbit};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start_i) begin
      dvd_d  = dividend_i;
      dvs_d  = divisor_i;
      rem_d  = '0;
      cnt_d  = CW'(DVD_W);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = dvd_q[QUO_W-1:0];

endmodule

// File: rtl/blob_centroid.sv
// Per-frame centroid, bounding box and hit count of pixels
// brighter than a threshold; result held until downstream accepts.
module blob_centroid
  import img_proc_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int PIX_W   = DEF_PIX_W,
  parameter int COORD_W = 11
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [PIX_W-1:0]    iColor,
  input  logic                iDVAL,
  input  logic [PIX_W-1:0]    iThreshold,
  input  logic                iRDY,
  output logic [COORD_W-1:0]  oX,
  output logic [COORD_W-1:0]  oY,
  output logic [COORD_W-1:0]  oXmin,
  output logic [COORD_W-1:0]  oXmax,
  output logic [COORD_W-1:0]  oYmin,
  output logic [COORD_W-1:0]  oYmax,
  output logic [$clog2(FRAME_W*FRAME_H+1)-1:0] oCount,
  output logic                oFound,
  output logic                oDVAL,
  output logic                oDrop
);

  localparam int CNT_W = $clog2(FRAME_W * FRAME_H + 1);
  localparam int SUM_W = COORD_W + CNT_W;

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [SUM_W-1:0]   sx_q, sx_d, sx_n, sy_q, sy_d, sy_n;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_n;
  logic [COORD_W-1:0] xmn_q, xmn_d, xmn_n, xmx_q, xmx_d, xmx_n;
  logic [COORD_W-1:0] ymn_q, ymn_d, ymn_n, ymx_q, ymx_d, ymx_n;

  logic [SUM_W-1:0]   ssx_q, ssx_d, ssy_q, ssy_d;
  logic [CNT_W-1:0]   scnt_q, scnt_d;
  logic [COORD_W-1:0] sxmn_q, sxmn_d, sxmx_q, sxmx_d;
  logic [COORD_W-1:0] symn_q, symn_d, symx_q, symx_d;
  logic [COORD_W-1:0] ox_q, ox_d, oy_q, oy_d;
  logic               drop_q, drop_d;
  blob_state_t        st_q, st_d;

  logic x_last, y_last, last, hit, first, snap_ok;
  logic div_start, div_busy, div_done;
  logic [SUM_W-1:0]   div_dvd;
  logic [COORD_W-1:0] div_quo;

  // Accumulation path; the in-flight pixel is folded into the *_n values.
  always_comb begin
    x_last = (x_q == COORD_W'(FRAME_W - 1));
    y_last = (y_q == COORD_W'(FRAME_H - 1));
    last   = iDVAL && x_last && y_last;
    hit    = iDVAL && (iColor > iThreshold);
    first  = (cnt_q == '0);
    sx_n   = sx_q;
    sy_n   = sy_q;
    cnt_n  = cnt_q;
    xmn_n  = xmn_q;
    xmx_n  = xmx_q;
    ymn_n  = ymn_q;
    ymx_n  = ymx_q;
    if (hit) begin
      sx_n  = sx_q + SUM_W'(x_q);
      sy_n  = sy_q + SUM_W'(y_q);
      cnt_n = cnt_q + CNT_W'(1);
      xmn_n = (first || x_q < xmn_q) ? x_q : xmn_q;
      xmx_n = (first || x_q > xmx_q) ? x_q : xmx_q;
      ymn_n = (first || y_q < ymn_q) ? y_q : ymn_q;
      ymx_n = (first || y_q > ymx_q) ? y_q : ymx_q;
    end
    x_d = x_q;
    y_d = y_q;
    if (iDVAL) begin
      x_d = x_last ? '0 : x_q + COORD_W'(1);
      if (x_last) y_d = y_last ? '0 : y_q + COORD_W'(1);
    end
    sx_d  = last ? '0 : sx_n;
    sy_d  = last ? '0 : sy_n;
    cnt_d = last ? '0 : cnt_n;
    xmn_d = last ? '0 : xmn_n;
    xmx_d = last ? '0 : xmx_n;
    ymn_d = last ? '0 : ymn_n;
    ymx_d = last ? '0 : ymx_n;
  end

  always_comb begin
    snap_ok = last && (st_q == ST_IDLE);
    st_d    = st_q;
    ssx_d   = ssx_q;
    ssy_d   = ssy_q;
    scnt_d  = scnt_q;
    sxmn_d  = sxmn_q;
    sxmx_d  = sxmx_q;
    symn_d  = symn_q;
    symx_d  = symx_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    drop_d  = drop_q | (last && (st_q != ST_IDLE));
    case (st_q)
      ST_IDLE: begin
        if (snap_ok) begin
          ssx_d  = sx_n;
          ssy_d  = sy_n;
          scnt_d = cnt_n;
          sxmn_d = xmn_n;
          sxmx_d = xmx_n;
          symn_d = ymn_n;
          symx_d = ymx_n;
          ox_d   = '0;
          oy_d   = '0;
          st_d   = (cnt_n != '0) ? ST_DIV_X : ST_HOLD;
        end
      end
      ST_DIV_X: begin
        if (div_done) begin
          ox_d = div_quo;
          st_d = ST_DIV_Y;
        end
      end
      ST_DIV_Y: begin
        if (div_done) begin
          oy_d = div_quo;
          st_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (iRDY) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Divider restarts on DIV_Y entry, once the X done pulse has gone.
  assign div_start = ((st_q == ST_DIV_X) || (st_q == ST_DIV_Y))
                     && !div_busy && !div_done;
  assign div_dvd   = (st_q == ST_DIV_Y) ? ssy_q : ssx_q;

  seq_divider #(
    .DVD_W (SUM_W),
    .DVS_W (CNT_W),
    .QUO_W (COORD_W)
  ) u_div (
    .clk        (iCLK),
    .rst_n      (iRST),
    .start_i    (div_start),
    .dividend_i (div_dvd),
    .divisor_i  (scnt_q),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      x_q    <= '0;
      y_q    <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
      cnt_q  <= '0;
      xmn_q  <= '0;
      xmx_q  <= '0;
      ymn_q  <= '0;
      ymx_q  <= '0;
      ssx_q  <= '0;
      ssy_q  <= '0;
      scnt_q <= '0;
      sxmn_q <= '0;
      sxmx_q <= '0;
      symn_q <= '0;
      symx_q <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      drop_q <= 1'b0;
      st_q   <= ST_IDLE;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      cnt_q  <= cnt_d;
      xmn_q  <= xmn_d;
      xmx_q  <= xmx_d;
      ymn_q  <= ymn_d;
      ymx_q  <= ymx_d;
      ssx_q  <= ssx_d;
      ssy_q  <= ssy_d;
      scnt_q <= scnt_d;
      sxmn_q <= sxmn_d;
      sxmx_q <= sxmx_d;
      symn_q <= symn_d;
      symx_q <= symx_d;
      ox_q   <= ox_d;
      oy_q   <= oy_d;
      drop_q <= drop_d;
      st_q   <= st_d;
    end
  end

  assign oX     = ox_q;
  assign oY     = oy_q;
  assign oXmin  = sxmn_q;
  assign oXmax  = sxmx_q;
  assign oYmin  = symn_q;
  assign oYmax  = symx_q;
  assign oCount = scnt_q;
  assign oFound = (scnt_q != '0);
  assign oDVAL  = (st_q == ST_HOLD);
  assign oDrop  = drop_q;

endmodule
